// File: rtl/memory_m_pkg.sv
// Shared types and helpers for the synchronous scratch RAM.
package memory_m_pkg;

    typedef enum logic {CLEAR, IDLE} mem_state_t;

    localparam int MAX_RD_LAT = 4;

    function automatic int lane_count(input int dwidth);
        return dwidth / 8;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read return path: RD_LAT-deep {valid, data} shift register.
// The last stage only reloads on valid so read data holds between reads.
module mem_rd_pipe #(
    parameter int DWIDTH = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [DWIDTH-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DWIDTH-1:0] out_data_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [DWIDTH-1:0] dat_q [RD_LAT];
    logic [RD_LAT-1:0] vld_d;
    logic [DWIDTH-1:0] dat_d [RD_LAT];

    always_comb begin
        vld_d[0] = in_valid_i;
        dat_d[0] = in_data_i;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < RD_LAT; i++) begin
                if (i < RD_LAT - 1 || vld_d[i]) begin
                    dat_q[i] <= dat_d[i];
                end
            end
        end
    end

    assign out_valid_o = vld_q[RD_LAT-1];
    assign out_data_o  = dat_q[RD_LAT-1];

endmodule

// File: rtl/memory_sync_m.sv
// Synchronous single-port RAM with byte enables, read pipeline,
// illegal-command flag and post-reset hardware clear.
module memory_sync_m
    import memory_m_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int AWIDTH     = 5,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read,
    input  logic                write,
    input  logic [AWIDTH-1:0]   addr,
    input  logic [DWIDTH-1:0]   wdata,
    input  logic [DWIDTH/8-1:0] be,
    output logic                ready,
    output logic [DWIDTH-1:0]   rdata,
    output logic                rvalid,
    output logic                err
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam int NLANE = lane_count(DWIDTH);

    if (DWIDTH % 8 != 0) begin : g_bad_dwidth
        $fatal(1, "memory_sync_m: DWIDTH must be a multiple of 8");
    end
    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
        $fatal(1, "memory_sync_m: RD_LAT must be in 1..4");
    end

    mem_state_t        state_q, state_d;
    logic [AWIDTH:0]   cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              wr_en, rd_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic [NLANE-1:0]  wr_be;
    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_d   = 1'b0;
        wr_addr = addr;
        wr_data = wdata;
        wr_be   = be;
        unique case (state_q)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q[AWIDTH-1:0];
                wr_data = '0;
                wr_be   = '1;
                cnt_d   = cnt_q + (AWIDTH+1)'(1);
                // Counter MSB set means the last word was just zeroed
                if (cnt_d[AWIDTH]) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                wr_en = ready_q & write & ~read;
                rd_en = ready_q & read & ~write;
                err_d = ready_q & read & write;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; only the CLEAR walk initialises them
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NLANE; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    mem_rd_pipe #(
        .DWIDTH (DWIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (rd_en),
        .in_data_i   (mem_q[addr]),
        .out_valid_o (rvalid),
        .out_data_o  (rdata)
    );

    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_memory_sync_m.sv
// Self-checking bench for memory_sync_m against a queue/array reference model.
module tb_memory_sync_m;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int RL    = 3;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [1:0]    be = '0;
    logic          ready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          err;

    memory_sync_m #(
        .DWIDTH     (DW),
        .AWIDTH     (AW),
        .RD_LAT     (RL),
        .INIT_CLEAR (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .read   (read),
        .write  (write),
        .addr   (addr),
        .wdata  (wdata),
        .be     (be),
        .ready  (ready),
        .rdata  (rdata),
        .rvalid (rvalid),
        .err    (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] model [DEPTH];
    int            edges;
    int            due_q[$];
    logic [DW-1:0] dat_q[$];
    logic [DW-1:0] last_rd;
    logic          e_rdy, e_rv, e_err;
    logic [DW-1:0] e_rd;

    // Drive one cycle of request, advance one edge, update the reference model.
    task automatic step(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [1:0] b);
        logic acc;
        read = rd; write = wr; addr = a; wdata = d; be = b;
        acc = (edges >= DEPTH);
        @(posedge clk);
        #1;
        edges++;
        if (acc && wr && !rd) begin
            for (int i = 0; i < 2; i++) begin
                if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
            end
        end
        if (acc && rd && !wr) begin
            due_q.push_back(edges + RL - 1);
            dat_q.push_back(model[a]);
        end
        e_err = acc && rd && wr;
        e_rdy = (edges >= DEPTH);
        e_rv  = 1'b0;
        if (due_q.size() > 0 && due_q[0] == edges) begin
            e_rv = 1'b1;
            last_rd = dat_q.pop_front();
            void'(due_q.pop_front());
        end
        e_rd = last_rd;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic assert_rst();
        read = 1'b0; write = 1'b0;
        #2 rst = 1'b1;
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        edges = 0;
        due_q.delete();
        dat_q.delete();
        last_rd = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        vectors++;
        if ({ready, rvalid, err, rdata} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b rv=%b err=%b rd=%h, want all 0",
                     ready, rvalid, err, rdata);
        end
        release_rst();
        for (int c = 0; c < DEPTH + 2; c++) begin
            if (c == 4) step(1'b0, 1'b1, 5'd0, 16'h00FF, 2'b11);
            else if (c == 6) step(1'b1, 1'b1, 5'd1, 16'h1111, 2'b11);
            else if (c == 8) step(1'b1, 1'b0, 5'd2, 16'h0, 2'b00);
            else step(1'b0, 1'b0, '0, '0, 2'b00);
            vectors++;
            if ({ready, rvalid, err, rdata} !== {e_rdy, e_rv, e_err, e_rd}) begin
                miscompares++;
                $display("FAIL clear_seq c=%0d: got rdy=%b rv=%b err=%b rd=%h, want rdy=%b rv=%b err=%b rd=%h",
                         c, ready, rvalid, err, rdata, e_rdy, e_rv, e_err, e_rd);
            end
        end
    endtask

    task automatic test_clear_reads();
        for (int c = 0; c < DEPTH + RL; c++) begin
            step(c < DEPTH, 1'b0, AW'(c), '0, 2'b00);
            vectors++;
            if ({ready, rvalid, err, rdata} !== {e_rdy, e_rv, e_err, e_rd}) begin
                miscompares++;
                $display("FAIL clear_reads c=%0d: got rv=%b rd=%h err=%b, want rv=%b rd=%h err=%b",
                         c, rvalid, rdata, err, e_rv, e_rd, e_err);
            end
        end
        step(1'b1, 1'b0, 5'd0, '0, 2'b00);
        for (int c = 0; c < RL; c++) step(1'b0, 1'b0, '0, '0, 2'b00);
        vectors++;
        if (rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL write_during_clear: got %h, want 0000", rdata);
        end
    endtask

    task automatic test_byte_en();
        for (int c = 0; c < 3 + RL; c++) begin
            if (c == 0) step(1'b0, 1'b1, 5'd3, 16'hABCD, 2'b11);
            else if (c == 1) step(1'b0, 1'b1, 5'd3, 16'h1234, 2'b01);
            else if (c == 2) step(1'b1, 1'b0, 5'd3, '0, 2'b00);
            else step(1'b0, 1'b0, '0, '0, 2'b00);
            vectors++;
            if ({ready, rvalid, err, rdata} !== {e_rdy, e_rv, e_err, e_rd}) begin
                miscompares++;
                $display("FAIL byte_en c=%0d: got rv=%b rd=%h, want rv=%b rd=%h",
                         c, rvalid, rdata, e_rv, e_rd);
            end
        end
        vectors++;
        if (rdata !== 16'hAB34) begin
            miscompares++;
            $display("FAIL byte_en_merge: got %h, want ab34", rdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, AW'(k), DW'(k + 1), 2'b11);
        for (int c = 0; c < 8 + RL; c++) begin
            step(c < 8, 1'b0, AW'(c), '0, 2'b00);
            vectors++;
            if (c >= RL - 1 && c < RL - 1 + 8) begin
                if (rvalid !== 1'b1 || rdata !== DW'(c - RL + 2)) begin
                    miscompares++;
                    $display("FAIL back_to_back c=%0d: got rv=%b rd=%h, want rv=1 rd=%h",
                             c, rvalid, rdata, DW'(c - RL + 2));
                end
            end else if ({rvalid, rdata} !== {e_rv, e_rd}) begin
                miscompares++;
                $display("FAIL back_to_back_idle c=%0d: got rv=%b rd=%h, want rv=%b rd=%h",
                         c, rvalid, rdata, e_rv, e_rd);
            end
        end
    endtask

    task automatic test_illegal();
        for (int c = 0; c < 6 + RL; c++) begin
            if (c == 0) step(1'b0, 1'b1, 5'd5, 16'h005A, 2'b11);
            else if (c == 1 || c == 2 || c == 4) step(1'b1, 1'b1, 5'd5, 16'hFFFF, 2'b11);
            else if (c == 5) step(1'b1, 1'b0, 5'd5, '0, 2'b00);
            else step(1'b0, 1'b0, '0, '0, 2'b00);
            vectors++;
            if ({ready, rvalid, err, rdata} !== {e_rdy, e_rv, e_err, e_rd}) begin
                miscompares++;
                $display("FAIL illegal c=%0d: got rv=%b err=%b rd=%h, want rv=%b err=%b rd=%h",
                         c, rvalid, err, rdata, e_rv, e_err, e_rd);
            end
        end
        vectors++;
        if (rdata !== 16'h005A) begin
            miscompares++;
            $display("FAIL illegal_preserve: got %h, want 005a", rdata);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic rd, wr;
            int sel;
            sel = $urandom_range(0, 9);
            rd = (sel < 4) || (sel == 9);
            wr = (sel >= 4 && sel < 8) || (sel == 9);
            step(rd, wr, AW'($urandom), DW'($urandom), 2'($urandom));
            vectors++;
            if ({ready, rvalid, err, rdata} !== {e_rdy, e_rv, e_err, e_rd}) begin
                miscompares++;
                $display("FAIL random c=%0d: got rv=%b err=%b rd=%h, want rv=%b err=%b rd=%h",
                         c, rvalid, err, rdata, e_rv, e_err, e_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, '0, '0, 2'b00);
        for (int c = 0; c < RL + 2; c++) step(1'b1, 1'b0, AW'(c), '0, 2'b00);
        assert_rst();
        release_rst();
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, '0, '0, 2'b00);
        assert_rst();
        vectors++;
        if ({ready, rvalid, err, rdata} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_mid_clear: got rdy=%b rv=%b err=%b rd=%h, want all 0",
                     ready, rvalid, err, rdata);
        end
        release_rst();
        for (int c = 0; c < DEPTH + 2; c++) begin
            step(1'b0, 1'b0, '0, '0, 2'b00);
            vectors++;
            if ({ready, rvalid, err} !== {e_rdy, e_rv, e_err}) begin
                miscompares++;
                $display("FAIL reclear c=%0d: got rdy=%b rv=%b err=%b, want rdy=%b rv=%b err=%b",
                         c, ready, rvalid, err, e_rdy, e_rv, e_err);
            end
        end
        step(1'b0, 1'b1, 5'd7, 16'hBEEF, 2'b11);
        step(1'b1, 1'b0, 5'd7, '0, 2'b00);
        step(1'b1, 1'b0, 5'd7, '0, 2'b00);
        assert_rst();
        vectors++;
        if ({ready, rvalid, err, rdata} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_mid_read: got rdy=%b rv=%b err=%b rd=%h, want all 0",
                     ready, rvalid, err, rdata);
        end
        release_rst();
        for (int c = 0; c < DEPTH + 2; c++) begin
            step(1'b0, 1'b0, '0, '0, 2'b00);
            vectors++;
            if ({ready, rvalid, err, rdata} !== {e_rdy, e_rv, e_err, e_rd}) begin
                miscompares++;
                $display("FAIL no_stale_rvalid c=%0d: got rdy=%b rv=%b rd=%h, want rdy=%b rv=%b rd=%h",
                         c, ready, rvalid, rdata, e_rdy, e_rv, e_rd);
            end
        end
        step(1'b1, 1'b0, 5'd7, '0, 2'b00);
        for (int c = 0; c < RL; c++) step(1'b0, 1'b0, '0, '0, 2'b00);
        vectors++;
        if (rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL reclear_content: got %h, want 0000", rdata);
        end
    endtask

    initial begin
        edges = 0;
        last_rd = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        test_reset();
        test_clear_reads();
        test_byte_en();
        test_back_to_back();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
